// File: rtl/serial_frame_tx_if.sv
// serial_frame_tx_if: valid/ready word-input handshake for serial_frame_tx
//   DATA_IN   word to transmit (master -> slave)
//   VALID_IN  DATA_IN valid    (master -> slave)
//   READY_OUT FIFO has room    (slave -> master)
interface serial_frame_tx_if #(parameter int WIDTH = 8);
    logic [WIDTH-1:0] DATA_IN;
    logic             VALID_IN;
    logic             READY_OUT;
    modport master (output DATA_IN, VALID_IN, input READY_OUT);
    modport slave (input DATA_IN, VALID_IN, output READY_OUT);
endinterface

// File: rtl/serial_frame_tx.sv
// serial_frame_tx: FIFO-buffered parallel-to-serial frame transmitter (start 1, LSB-first data, 0 gap)
//   clock  rising-edge clock
//   reset  asynchronous active-low reset
//   in_if  word input handshake (DATA_IN, VALID_IN, READY_OUT)
//   X_OUT  registered serial line, idles at 0
//   BUSY   frame in progress or FIFO non-empty
//   LEVEL  FIFO occupancy
module serial_frame_tx #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int GAP   = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    serial_frame_tx_if.slave         in_if,
    output logic                     X_OUT,
    output logic                     BUSY,
    output logic [$clog2(DEPTH):0]   LEVEL
);
    localparam int AW = $clog2(DEPTH);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int GW = GAP > 1 ? $clog2(GAP) : 1;
    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_GAP} state_t;
    state_t           state, state_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [WIDTH-1:0] shift, shift_d;
    logic [BW-1:0]    bit_cnt, bit_d;
    logic [GW-1:0]    gap_cnt, gap_d;
    logic             x_d, push, pop;
    assign in_if.READY_OUT = LEVEL < (AW+1)'(DEPTH);
    assign push = in_if.VALID_IN & in_if.READY_OUT;
    assign BUSY = (state != S_IDLE) | (LEVEL != '0);
    always_ff @(posedge clock)
        if (push) mem[wr_ptr] <= in_if.DATA_IN;
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state   <= S_IDLE;
            X_OUT   <= 1'b0;
            shift   <= '0;
            bit_cnt <= '0;
            gap_cnt <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            LEVEL   <= '0;
        end else begin
            state   <= state_d;
            X_OUT   <= x_d;
            shift   <= shift_d;
            bit_cnt <= bit_d;
            gap_cnt <= gap_d;
            wr_ptr  <= wr_ptr + AW'(push);
            rd_ptr  <= rd_ptr + AW'(pop);
            LEVEL   <= LEVEL + (AW+1)'(push) - (AW+1)'(pop);
        end
    end
    // The shift register shifts right each bit so the LSB is always the next bit to drive.
    always_comb begin
        state_d = state;
        x_d     = 1'b0;
        shift_d = shift;
        bit_d   = bit_cnt;
        gap_d   = gap_cnt;
        pop     = 1'b0;
        case (state)
            S_IDLE: if (LEVEL != '0) begin
                pop     = 1'b1;
                shift_d = mem[rd_ptr];
                x_d     = 1'b1;
                state_d = S_START;
            end
            S_START: begin
                x_d     = shift[0];
                shift_d = shift >> 1;
                bit_d   = BW'(1);
                state_d = S_DATA;
            end
            S_DATA: if (bit_cnt == BW'(WIDTH)) begin
                gap_d   = '0;
                state_d = GAP > 0 ? S_GAP : S_IDLE;
            end else begin
                x_d     = shift[0];
                shift_d = shift >> 1;
                bit_d   = bit_cnt + 1'b1;
            end
            S_GAP: begin
                gap_d   = gap_cnt + 1'b1;
                state_d = gap_cnt == GW'(GAP - 1) ? S_IDLE : S_GAP;
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_serial_frame_tx.sv
// tb_serial_frame_tx: directed self-checking bench for serial_frame_tx (GAP=2 and GAP=0 builds)
module tb_serial_frame_tx;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       x, busy, x0, busy0;
    logic [2:0] level, level0;
    int         total = 0;
    int         bad = 0;
    serial_frame_tx_if #(.WIDTH(8)) in_if ();
    serial_frame_tx_if #(.WIDTH(8)) in_if0 ();
    serial_frame_tx #(.WIDTH(8), .DEPTH(4), .GAP(2)) u (
        .clock(clock), .reset(reset), .in_if(in_if), .X_OUT(x), .BUSY(busy), .LEVEL(level));
    serial_frame_tx #(.WIDTH(8), .DEPTH(4), .GAP(0)) u0 (
        .clock(clock), .reset(reset), .in_if(in_if0), .X_OUT(x0), .BUSY(busy0), .LEVEL(level0));
    always #5 clock = ~clock;
    task automatic tick();
        @(posedge clock);
        #1;
    endtask
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%0h exp=%0h at %0t", name, act, exp, $time);
        end
    endtask
    typedef struct {
        logic [7:0]  data;
        logic [12:0] exp;
    } vec_t;
    vec_t       vecs[5];
    logic [7:0] words[6];
    logic       exp_x, rdy;
    int         idx, j, t;
    initial begin
        // X_OUT after E1..E13, E1 in the MSB
        vecs[0] = '{8'hA5, 13'b1101001010000};
        vecs[1] = '{8'h01, 13'b1100000000000};
        vecs[2] = '{8'h80, 13'b1000000010000};
        vecs[3] = '{8'hFF, 13'b1111111110000};
        vecs[4] = '{8'h3C, 13'b1001111000000};
        words = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        in_if.VALID_IN = 1'b0;
        in_if.DATA_IN = '0;
        in_if0.VALID_IN = 1'b0;
        in_if0.DATA_IN = '0;
        // 1: outputs stay at reset values while reset held, regardless of inputs
        for (int i = 0; i < 6; i++) begin
            in_if.VALID_IN = i[0];
            in_if.DATA_IN = 8'hFF;
            in_if0.VALID_IN = ~i[0];
            tick();
            check("rst_x", x, 0);
            check("rst_level", level, 0);
            check("rst_ready", in_if.READY_OUT, 1);
            check("rst_busy", busy, 0);
            check("rst_x0", x0, 0);
            check("rst_level0", level0, 0);
        end
        in_if.VALID_IN = 1'b0;
        in_if0.VALID_IN = 1'b0;
        #3 reset = 1'b1;
        tick();
        // 2: single-word frames from the table
        foreach (vecs[v]) begin
            in_if.VALID_IN = 1'b1;
            in_if.DATA_IN = vecs[v].data;
            tick();
            in_if.VALID_IN = 1'b0;
            check("t2_level_e0", level, 1);
            for (int e = 1; e <= 13; e++) begin
                tick();
                check("t2_x", x, 32'(vecs[v].exp[13-e]));
                if (e == 1) check("t2_level_e1", level, 0);
                if (e == 11) check("t2_busy_e11", busy, 1);
                if (e == 13) check("t2_busy_e13", busy, 0);
            end
        end
        // 3 and 5: burst of six words; the sixth is held while full and refused on the pop edge
        idx = 0;
        for (int cyc = 0; cyc <= 72; cyc++) begin
            rdy = in_if.READY_OUT;
            in_if.VALID_IN = idx < 6;
            in_if.DATA_IN = words[idx < 6 ? idx : 5];
            tick();
            if (in_if.VALID_IN && rdy) idx++;
            if (cyc >= 1) begin
                j = (cyc - 1) / 12;
                t = (cyc - 1) % 12;
                exp_x = t == 0 ? 1'b1 : (t <= 8 ? words[j][t-1] : 1'b0);
                check("t3_x", x, 32'(exp_x));
            end
            if (cyc == 4) begin
                check("t3_level_full", level, 4);
                check("t3_ready_full", in_if.READY_OUT, 0);
            end
            if (cyc == 12) check("t3_level_e12", level, 4);
            if (cyc == 13) begin
                check("t5_level_pop", level, 3);
                check("t5_idx_pop", idx, 5);
            end
            if (cyc == 14) check("t5_level_refill", level, 4);
        end
        in_if.VALID_IN = 1'b0;
        check("t3_all_accepted", idx, 6);
        check("t3_busy_end", busy, 0);
        // 4: GAP=0 build, two 0xFF words back to back
        idx = 0;
        for (int cyc = 0; cyc <= 21; cyc++) begin
            in_if0.VALID_IN = idx < 2;
            in_if0.DATA_IN = 8'hFF;
            tick();
            if (in_if0.VALID_IN) idx++;
            if (cyc >= 1) begin
                t = (cyc - 1) % 10;
                exp_x = cyc <= 20 && t != 9;
                check("t4_x0", x0, 32'(exp_x));
            end
            if (cyc == 1) check("t4_level_e1", level0, 1);
            if (cyc == 11) check("t4_level_e11", level0, 0);
        end
        in_if0.VALID_IN = 1'b0;
        check("t4_busy_end", busy0, 0);
        // 6: asynchronous reset mid-frame discards the frame and the queue
        in_if.VALID_IN = 1'b1;
        in_if.DATA_IN = 8'h5A;
        tick();
        in_if.DATA_IN = 8'h11;
        tick();
        in_if.DATA_IN = 8'h22;
        tick();
        in_if.VALID_IN = 1'b0;
        check("t6_level_q", level, 2);
        tick();
        tick();
        tick();
        check("t6_bit3", x, 1);
        #2 reset = 1'b0;
        #1;
        check("t6_x_async", x, 0);
        check("t6_level_async", level, 0);
        check("t6_busy_async", busy, 0);
        check("t6_ready_async", in_if.READY_OUT, 1);
        #2 reset = 1'b1;
        for (int e = 0; e < 15; e++) begin
            tick();
            check("t6_x_after", x, 0);
            check("t6_level_after", level, 0);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
